// File: rtl/regfile_ctrl_pkg.sv
// rtl/regfile_ctrl_pkg.sv - shared parameters and types for the register file controller
package regfile_ctrl_pkg;

    localparam int NREG    = 32;
    localparam int DATA_W  = 64;
    localparam int CNT_W   = 2;
    localparam int IDX_W   = $clog2(NREG);
    localparam int ZR      = 31;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef logic [IDX_W-1:0] reg_idx_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register in-flight write counters with hazard lookups
module regfile_scoreboard
    import regfile_ctrl_pkg::*;
(
    input  logic     clock,
    input  logic     reset_n,
    input  logic     inc_en,
    input  reg_idx_t inc_idx,
    input  logic     dec_en,
    input  reg_idx_t dec_idx,
    input  logic     clr,
    input  reg_idx_t look_a,
    input  reg_idx_t look_b,
    input  reg_idx_t look_c,
    output logic     a_busy,
    output logic     b_busy,
    output logic     c_full,
    output logic     ovf_pulse,
    output logic     unf_pulse
);

    cnt_t            pend [NREG];
    logic [NREG-1:0] inc_hit;
    logic [NREG-1:0] dec_hit;
    logic            inc_live;
    logic            dec_live;
    logic            same_reg;

    // Decode the increment/decrement targets; the zero register is never tracked
    always_comb begin
        inc_hit  = '0;
        dec_hit  = '0;
        inc_live = inc_en && (inc_idx != reg_idx_t'(ZR));
        dec_live = dec_en && (dec_idx != reg_idx_t'(ZR));
        same_reg = inc_live && dec_live && (inc_idx == dec_idx);
        if (inc_live) inc_hit[inc_idx] = 1'b1;
        if (dec_live) dec_hit[dec_idx] = 1'b1;
    end

    // Counter update: flush wins, a simultaneous inc and dec on one register cancel
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) pend[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < NREG; i++) pend[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (inc_hit[i] && !dec_hit[i] && pend[i] != cnt_t'(CNT_MAX))
                    pend[i] <= pend[i] + cnt_t'(1);
                else if (dec_hit[i] && !inc_hit[i] && pend[i] != '0)
                    pend[i] <= pend[i] - cnt_t'(1);
            end
        end
    end

    // Hazard lookups and error detection on the current counts
    always_comb begin
        a_busy    = (pend[look_a] != '0);
        b_busy    = (pend[look_b] != '0);
        c_full    = (pend[look_c] == cnt_t'(CNT_MAX));
        ovf_pulse = inc_live && !same_reg && (pend[inc_idx] == cnt_t'(CNT_MAX));
        unf_pulse = dec_live && !same_reg && (pend[dec_idx] == '0);
    end

endmodule

// File: rtl/regfile_ctrl.sv
// rtl/regfile_ctrl.sv - register file zero-fill sequencer, write-port owner and issue hazard stall
module regfile_ctrl
    import regfile_ctrl_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              iss_valid,
    input  logic [IDX_W-1:0]  iss_rn,
    input  logic [IDX_W-1:0]  iss_rm,
    input  logic [IDX_W-1:0]  iss_rd,
    input  logic              iss_wr,
    output logic              iss_stall,
    input  logic              wb_valid,
    input  logic [IDX_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              rf_we,
    output logic [IDX_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              init_done,
    output logic              err_ovf,
    output logic              err_unf
);

    state_t   state;
    state_t   state_nxt;
    reg_idx_t init_cnt;
    logic     run;
    logic     a_busy;
    logic     b_busy;
    logic     c_full;
    logic     stall_run;
    logic     accept;
    logic     ovf_pulse;
    logic     unf_pulse;

    assign run       = (state == RUN);
    assign stall_run = iss_valid && (a_busy || b_busy || (iss_wr && c_full));
    assign accept    = run && iss_valid && !stall_run;

    regfile_scoreboard u_scoreboard (
        .clock     (clock),
        .reset_n   (reset_n),
        .inc_en    (accept && iss_wr),
        .inc_idx   (iss_rd),
        .dec_en    (run && wb_valid),
        .dec_idx   (wb_rd),
        .clr       (run && flush),
        .look_a    (iss_rn),
        .look_b    (iss_rm),
        .look_c    (iss_rd),
        .a_busy    (a_busy),
        .b_busy    (b_busy),
        .c_full    (c_full),
        .ovf_pulse (ovf_pulse),
        .unf_pulse (unf_pulse)
    );

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= INIT;
        else          state <= state_nxt;
    end

    // Leave INIT once the last register address has been zero-filled
    always_comb begin
        state_nxt = state;
        if (state == INIT && init_cnt == reg_idx_t'(NREG - 1))
            state_nxt = RUN;
    end

    // Zero-fill address counter, advancing one register per INIT cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)           init_cnt <= '0;
        else if (state == INIT) init_cnt <= init_cnt + reg_idx_t'(1);
    end

    // init_done rises the edge after RUN is entered and holds until reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) init_done <= 1'b0;
        else if (run) init_done <= 1'b1;
    end

    // Sticky scoreboard error flags
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            if (ovf_pulse) err_ovf <= 1'b1;
            if (unf_pulse) err_unf <= 1'b1;
        end
    end

    // Write-port mux and issue stall; everything is quiet while reset is held
    always_comb begin
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        iss_stall = 1'b0;
        if (reset_n) begin
            case (state)
                INIT: begin
                    rf_we     = 1'b1;
                    rf_waddr  = init_cnt;
                    iss_stall = 1'b1;
                end
                RUN: begin
                    rf_we     = wb_valid && (wb_rd != reg_idx_t'(ZR));
                    rf_waddr  = wb_rd;
                    rf_wdata  = wb_data;
                    iss_stall = stall_run;
                end
                default: ;
            endcase
        end
    end

endmodule
